// File: rtl/v_mem_seq.sv
// rtl/v_mem_seq.sv - vector load/store sequencer for the 4-bank data memory
// Turns one unit-stride request into 128-bit row beats; loads return through a 3-entry skid FIFO.
module v_mem_seq #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BEAT_W = 5
) (
    input  logic                core_clk,
    input  logic                nrst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [ADDR_W-1:0]   req_base,
    input  logic [BEAT_W-1:0]   req_beats,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [4*DATA_W-1:0] st_data,
    output logic                ld_valid,
    input  logic                ld_ready,
    output logic [4*DATA_W-1:0] ld_data,
    output logic                ld_last,
    output logic                done,
    output logic                err,
    output logic [3:0]          dm_write,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_in_0,
    output logic [DATA_W-1:0]   data_in_1,
    output logic [DATA_W-1:0]   data_in_2,
    output logic [DATA_W-1:0]   data_in_3,
    input  logic [DATA_W-1:0]   data_out_0,
    input  logic [DATA_W-1:0]   data_out_1,
    input  logic [DATA_W-1:0]   data_out_2,
    input  logic [DATA_W-1:0]   data_out_3
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(16);
    localparam int                BEAT_BITS = 4 * DATA_W;

    logic [1:0]           state;
    logic [ADDR_W-1:0]    cur;
    logic [BEAT_W-1:0]    rem;
    logic [BEAT_W-1:0]    issued;
    logic [BEAT_W-1:0]    beats_q;
    logic                 inflight;
    logic                 inflight_last;

    logic [BEAT_BITS-1:0] fifo_data [3];
    logic [2:0]           fifo_last;
    logic [1:0]           fifo_cnt;
    logic [1:0]           wr_idx;

    logic [ADDR_W-1:0]    req_end;
    logic                 req_bad;
    logic                 accept;
    logic                 issue;
    logic                 issue_last;
    logic                 push;
    logic                 pop;
    logic                 pop_last;
    logic [BEAT_BITS-1:0] push_data;

    // A request may not straddle the protocol-region boundary; stores may not enter it at all.
    assign req_end = req_base + ADDR_W'(req_beats) - ADDR_W'(1);
    assign req_bad = (req_beats == '0) || (req_beats > MAX_BEATS) ||
                     (req_base[ADDR_W-1] != req_end[ADDR_W-1]) ||
                     (req_store && req_base[ADDR_W-1]);

    assign req_ready = nrst && (state == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign st_ready  = nrst && (state == S_STORE);

    // Reads are throttled so FIFO occupancy plus the read in flight never exceeds the 3 entries.
    assign issue      = (state == S_LOAD) && (issued < beats_q) &&
                        (({1'b0, fifo_cnt} + {2'b0, inflight}) <= 3'd2);
    assign issue_last = issue && (issued == beats_q - BEAT_W'(1));

    assign push      = inflight;
    assign pop       = ld_valid && ld_ready;
    assign pop_last  = pop && fifo_last[0];
    assign wr_idx    = fifo_cnt - 2'(pop);
    assign push_data = {data_out_3, data_out_2, data_out_1, data_out_0};

    assign ld_valid = (fifo_cnt != 2'd0);
    assign ld_data  = fifo_data[0];
    assign ld_last  = fifo_last[0];

    assign dm_write  = (nrst && (state == S_STORE) && st_valid) ? 4'hF : 4'h0;
    assign data_addr = (nrst && (state != S_IDLE)) ? cur : '0;
    assign data_in_0 = st_data[0*DATA_W +: DATA_W];
    assign data_in_1 = st_data[1*DATA_W +: DATA_W];
    assign data_in_2 = st_data[2*DATA_W +: DATA_W];
    assign data_in_3 = st_data[3*DATA_W +: DATA_W];

    always_ff @(posedge core_clk) begin
        if (!nrst) begin
            state         <= S_IDLE;
            cur           <= '0;
            rem           <= '0;
            issued        <= '0;
            beats_q       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue_last;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur     <= req_base;
                        rem     <= req_beats;
                        beats_q <= req_beats;
                        issued  <= '0;
                        if (req_bad) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state <= req_store ? S_STORE : S_LOAD;
                        end
                    end
                end
                S_STORE: begin
                    if (st_valid) begin
                        cur <= cur + ADDR_W'(1);
                        rem <= rem - BEAT_W'(1);
                        if (rem == BEAT_W'(1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (issue) begin
                        cur    <= cur + ADDR_W'(1);
                        issued <= issued + BEAT_W'(1);
                        if (issue_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shift-style FIFO: entry 0 is always the head, so ld_data comes straight from a register.
    always_ff @(posedge core_clk) begin
        if (!nrst) begin
            fifo_cnt  <= 2'd0;
            fifo_last <= 3'b000;
        end else begin
            if (pop) fifo_last <= {1'b0, fifo_last[2:1]};
            if (push) fifo_last[wr_idx] <= inflight_last;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge core_clk) begin
        if (pop) begin
            fifo_data[0] <= fifo_data[1];
            fifo_data[1] <= fifo_data[2];
        end
        if (push) fifo_data[wr_idx] <= push_data;
    end

    always_ff @(posedge core_clk) begin
        if (nrst) assert (!(push && !pop && (fifo_cnt == 2'd3)));
    end

endmodule

// File: tb/tb_v_mem_seq.sv
// tb/tb_v_mem_seq.sv - directed self-checking bench for v_mem_seq
module tb_v_mem_seq;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int BEAT_W = 5;

    logic                core_clk = 1'b0;
    logic                nrst;
    logic                req_valid;
    logic                req_ready;
    logic                req_store;
    logic [ADDR_W-1:0]   req_base;
    logic [BEAT_W-1:0]   req_beats;
    logic                st_valid;
    logic                st_ready;
    logic [4*DATA_W-1:0] st_data;
    logic                ld_valid;
    logic                ld_ready;
    logic [4*DATA_W-1:0] ld_data;
    logic                ld_last;
    logic                done;
    logic                err;
    logic [3:0]          dm_write;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_in_0, data_in_1, data_in_2, data_in_3;
    logic [DATA_W-1:0]   data_out_0, data_out_1, data_out_2, data_out_3;

    logic [127:0] mem    [0:16383];
    logic [127:0] shadow [0:16383];
    logic [127:0] mem_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 core_clk = ~core_clk;

    v_mem_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEAT_W(BEAT_W)) dut (
        .core_clk(core_clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_beats(req_beats),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .done(done), .err(err), .dm_write(dm_write), .data_addr(data_addr),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3)
    );

    // 4-bank memory, one registered read per cycle
    always @(posedge core_clk) begin
        if (dm_write == 4'hF) mem[data_addr] <= {data_in_3, data_in_2, data_in_1, data_in_0};
        mem_q <= mem[data_addr];
    end
    assign data_out_0 = mem_q[31:0];
    assign data_out_1 = mem_q[63:32];
    assign data_out_2 = mem_q[95:64];
    assign data_out_3 = mem_q[127:96];

    function automatic logic [127:0] row_pat(input int row);
        return {32'hA300_0000 + row, 32'hA200_0000 + row, 32'hA100_0000 + row, 32'hA000_0000 + row};
    endfunction

    function automatic logic [127:0] st_pat(input int row);
        return {32'hD300_0000 + row, 32'hD200_0000 + row, 32'hD100_0000 + row, 32'hD000_0000 + row};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge core_clk);
        #1;
    endtask

    task automatic do_store(input int base, input int beats, input bit busy_probe, input string tag);
        req_valid = 1'b1; req_store = 1'b1; req_base = ADDR_W'(base); req_beats = BEAT_W'(beats);
        @(negedge core_clk);
        check({tag, "_req_ready"}, req_ready, 1);
        next_cycle();
        req_valid = busy_probe; req_store = 1'b0; req_base = '0; req_beats = BEAT_W'(1);
        for (int i = 0; i < beats; i++) begin
            st_valid = 1'b1;
            st_data  = st_pat(base + i);
            @(negedge core_clk);
            check({tag, "_dm_write"}, dm_write, 4'hF);
            check({tag, "_addr"}, data_addr, base + i);
            check({tag, "_early_done"}, done, 0);
            if (busy_probe) check({tag, "_busy_req_ready"}, req_ready, 0);
            shadow[base + i] = st_pat(base + i);
            next_cycle();
        end
        req_valid = 1'b0; st_valid = 1'b0;
        @(negedge core_clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_dm_idle"}, dm_write, 0);
        next_cycle();
    endtask

    task automatic do_load(input int base, input int beats, input bit toggle, input bit exact, input string tag);
        int  got_n;
        int  cyc;
        bit  seen_done;
        req_valid = 1'b1; req_store = 1'b0; req_base = ADDR_W'(base); req_beats = BEAT_W'(beats);
        ld_ready  = 1'b1;
        @(negedge core_clk);
        check({tag, "_req_ready"}, req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
        got_n = 0; seen_done = 0; cyc = 0;
        while (!seen_done && cyc < 80) begin
            if (toggle) ld_ready = (cyc % 2 == 0);
            @(negedge core_clk);
            check({tag, "_dm_write"}, dm_write, 0);
            if (exact && cyc == 0) check({tag, "_first_addr"}, data_addr, base);
            if (exact && cyc < 2) check({tag, "_early_valid"}, ld_valid, 0);
            if (ld_valid && ld_ready) begin
                check({tag, "_data"}, ld_data, shadow[base + got_n]);
                check({tag, "_last"}, ld_last, (got_n == beats - 1));
                if (exact) check({tag, "_beat_cycle"}, cyc, 2 + got_n);
                got_n++;
            end
            if (done) begin
                seen_done = 1;
                check({tag, "_err"}, err, 0);
                check({tag, "_valid_after"}, ld_valid, 0);
                if (exact) check({tag, "_done_cycle"}, cyc, beats + 2);
            end
            cyc++;
            next_cycle();
        end
        check({tag, "_count"}, got_n, beats);
        check({tag, "_done"}, seen_done, 1);
        ld_ready = 1'b1;
    endtask

    task automatic do_bad(input bit store, input int base, input int beats, input string tag);
        req_valid = 1'b1; req_store = store; req_base = ADDR_W'(base); req_beats = BEAT_W'(beats);
        @(negedge core_clk);
        check({tag, "_dm_accept"}, dm_write, 0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge core_clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 1);
        check({tag, "_dm_write"}, dm_write, 0);
        check({tag, "_addr"}, data_addr, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        next_cycle();
        @(negedge core_clk);
        check({tag, "_done_once"}, done, 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 16384; r++) begin
            mem[r]    = row_pat(r);
            shadow[r] = row_pat(r);
        end
        nrst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_beats = '0;
        st_valid = 1'b0; st_data = '0; ld_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge core_clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_dm_write", dm_write, 0);
        check("rst_ld_valid", ld_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", data_addr, 0);
        next_cycle();
        nrst = 1'b1;
        @(negedge core_clk);
        check("idle_req_ready", req_ready, 1);
        next_cycle();

        do_store(32'h010, 4, 1'b0, "t1_store");
        do_load(32'h010, 4, 1'b0, 1'b1, "t2_load");
        do_load(32'h100, 8, 1'b1, 1'b0, "t3_toggle");
        do_load(32'h1FF0, 16, 1'b0, 1'b1, "t3_max");
        do_load(32'h040, 1, 1'b0, 1'b1, "t3_single");

        do_bad(1'b1, 32'h2000, 1, "t4_prot_store");
        do_bad(1'b0, 32'h1FFF, 2, "t4_straddle");
        do_bad(1'b0, 32'h0020, 0, "t4_zero");
        do_bad(1'b0, 32'h0020, 17, "t4_too_long");

        req_valid = 1'b1; req_store = 1'b1; req_base = ADDR_W'(32'h200); req_beats = BEAT_W'(4);
        next_cycle();
        req_valid = 1'b0;
        st_valid = 1'b1; st_data = st_pat(32'h200);
        @(negedge core_clk);
        check("t5_beat0_dm", dm_write, 4'hF);
        shadow[32'h200] = st_pat(32'h200);
        next_cycle();
        st_data = st_pat(32'h201); nrst = 1'b0;
        @(negedge core_clk);
        check("t5_rst_dm", dm_write, 0);
        check("t5_rst_req_ready", req_ready, 0);
        next_cycle();
        nrst = 1'b1; st_valid = 1'b0;
        @(negedge core_clk);
        check("t5_idle_req_ready", req_ready, 1);
        check("t5_idle_addr", data_addr, 0);
        check("t5_idle_done", done, 0);
        check("t5_idle_ld_valid", ld_valid, 0);
        next_cycle();
        do_load(32'h200, 2, 1'b0, 1'b1, "t5_load");

        do_store(32'h300, 4, 1'b1, "t6_store");
        do_load(32'h300, 4, 1'b1, 1'b0, "t6_load");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
